instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Parametrised fetch stage for the MIPS-DLX pipeline. It owns the PC register, drives a synchronous single-port instruction ROM (one-cycle read latency) and presents each fetched instruction with its PC+1 and a valid flag to the decode stage. Beyond the single-generation fetch stage, it adds:

- synchronous reset to a configurable vector;
- prioritised branch and jump redirects, each squashing the in-flight fetch;
- a downstream stall with a hold buffer, so no instruction is lost or duplicated.

## Interface
Parameters:
- ADDR_WIDTH, 10, instruction address width (word-addressed).
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, address fetched first after reset.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  decode cannot accept; hold the current instruction.
- branch_en  input  1  redirect to branch_address (priority over jump_en).
- branch_address  input  ADDR_WIDTH  branch target.
- jump_en  input  1  redirect to jump_address.
- jump_address  input  ADDR_WIDTH  jump target.
- imem_addr  output  ADDR_WIDTH  address to ROM; equals PC_q.
- imem_data  input  DATA_WIDTH  ROM read data; valid one cycle after the address.
- instruc_reg  output  DATA_WIDTH  instruction to decode; 0 when instr_valid=0.
- PC_plus_1  output  ADDR_WIDTH  address of instruc_reg plus 1 (mod 2^ADDR_WIDTH); 0 when invalid.
- instr_valid  output  1  instruc_reg/PC_plus_1 are meaningful.

## Operation
State:
- PC_q: address issued this cycle.
- resp_pc_q: address whose data is on imem_data.
- resp_valid_q
- hold_q: DATA_WIDTH hold buffer.
- hold_active_q

Per-edge priority (highest first):
- **reset:** PC_q<=RESET_PC, resp_valid_q<=0, resp_pc_q<=0, hold_active_q<=0, hold_q<=0.
- **redirect** (branch_en, else jump_en; overrides stall):
  - PC_q<=target, resp_valid_q<=0, hold_active_q<=0.
  - branch_en wins when both are set.
- **stall:**
  - PC_q, resp_pc_q and resp_valid_q hold.
  - If hold_active_q=0, hold_q<=imem_data and hold_active_q<=1; otherwise hold_q keeps its value.
- **advance:** PC_q<=PC_q+1, resp_pc_q<=PC_q, resp_valid_q<=1, hold_active_q<=0.

Outputs (combinational from state):
- instr_valid = resp_valid_q.
- instruc_reg = !resp_valid_q ? 0 : (hold_active_q ? hold_q : imem_data).
- PC_plus_1 = resp_valid_q ? resp_pc_q+1 : 0.

Arithmetic:
- All PC arithmetic is modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH-1 wraps to 0.

## Timing
- **Reset value of every output:** instr_valid=0, instruc_reg=0, PC_plus_1=0, imem_addr=RESET_PC.
- **After reset:** with cycle 1 the first cycle with reset low, imem_addr=RESET_PC in cycle 1. Cycle 2 shows instr_valid=1, instruc_reg=mem[RESET_PC], PC_plus_1=RESET_PC+1.
- **Steady state:** one instruction per cycle, consecutive addresses.
- **Redirect in cycle t:**
  - The output in cycle t is unaffected.
  - t+1: imem_addr=target, instr_valid=0 (one bubble).
  - t+2: mem[target] is valid.
- **Stall in cycles t..t+k-1:** the output stays identical to cycle t for all k cycles. In cycle t+k (stall low) the same instruction is shown once more, from hold_q if k≥1. The next sequential instruction appears in t+k+1, with no skip and no duplicate beyond the stall.
- **Stall and redirect together:** the redirect wins and the hold buffer is discarded.
- **Stall with instr_valid=0:** the bubble persists and no capture matters.
- **Reset mid-stall or mid-redirect:** reset wins; all state returns to reset values.

## Test plan
- **Reset/sequential:** RESET_PC=0, ROM[i]=i+0x100, reset 2 cycles then release → cycle 2 shows valid, 0x100, PC_plus_1=1; cycle 3 shows 0x101, PC_plus_1=2.
- **Jump:** jump_en in cycle 5 to 0x200 → cycle 6 instr_valid=0; cycle 7 shows ROM[0x200], PC_plus_1=0x201.
- **Priority:** branch_en (0x40) and jump_en (0x80) together → cycle t+2 shows ROM[0x40]; jump ignored.
- **Stall:** stall for 3 cycles while showing ROM[7] → ROM[7] for 4 cycles total, then ROM[8], ROM[9]; no gap or repeat.
- **Stall+redirect:** stall high plus jump_en to 0x10 → next cycle bubble, then ROM[0x10]; hold contents not seen.
- **Wrap/reset mid-op:** ADDR_WIDTH=4, run past 15 → ROM[15] then ROM[0], with PC_plus_1 0 then 1. Assert reset during a stall → instr_valid=0 next cycle, and the sequence restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives a one-cycle-latency instruction ROM and
// hands each instruction plus its PC+1 to decode, with redirect and stall.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_en,
    input  logic [ADDR_WIDTH-1:0] branch_address,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_address,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic [DATA_WIDTH-1:0] instruc_reg,
    output logic [ADDR_WIDTH-1:0] PC_plus_1,
    output logic                  instr_valid
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_active_q, hold_active_d;

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        resp_valid_d  = resp_valid_q;
        hold_d        = hold_q;
        hold_active_d = hold_active_q;
        if (branch_en) begin
            pc_d          = branch_address;
            resp_valid_d  = 1'b0;
            hold_active_d = 1'b0;
        end else if (jump_en) begin
            pc_d          = jump_address;
            resp_valid_d  = 1'b0;
            hold_active_d = 1'b0;
        end else if (stall) begin
            // The ROM moves on to PC_q next cycle, so capture the shown word once
            if (!hold_active_q) begin
                hold_d        = imem_data;
                hold_active_d = 1'b1;
            end
        end else begin
            pc_d          = pc_q + ADDR_WIDTH'(1);
            resp_pc_d     = pc_q;
            resp_valid_d  = 1'b1;
            hold_active_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= '0;
            resp_valid_q  <= 1'b0;
            hold_q        <= '0;
            hold_active_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            resp_valid_q  <= resp_valid_d;
            hold_q        <= hold_d;
            hold_active_q <= hold_active_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = resp_valid_q;
    assign instruc_reg = !resp_valid_q ? '0 :
                         (hold_active_q ? hold_q : imem_data);
    assign PC_plus_1   = resp_valid_q ? resp_pc_q + ADDR_WIDTH'(1) : '0;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: a 10-bit fetch unit and a 4-bit one (reset vector 13)
// driven by directed vectors; ROM word at address i is i+0x100.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic        v;
        logic [31:0] ins;
        logic [9:0]  pcp;
        logic [9:0]  addr;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stl, br, jp;
    logic [9:0]  ba, ja;
    logic [9:0]  addr10, pcp10;
    logic [31:0] data10, ins10;
    logic        v10;

    logic        rst4, stl4;
    logic [3:0]  addr4, pcp4;
    logic [31:0] data4, ins4;
    logic        v4;

    exp_t q10[$];
    exp_t q4[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc_n  = 0;

    instruction_fetch_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) u_dut (
        .clock(clk), .reset(rst), .stall(stl),
        .branch_en(br), .branch_address(ba),
        .jump_en(jp), .jump_address(ja),
        .imem_addr(addr10), .imem_data(data10),
        .instruc_reg(ins10), .PC_plus_1(pcp10), .instr_valid(v10)
    );

    instruction_fetch_unit #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .RESET_PC(4'd13)
    ) u_dut4 (
        .clock(clk), .reset(rst4), .stall(stl4),
        .branch_en(1'b0), .branch_address(4'd0),
        .jump_en(1'b0), .jump_address(4'd0),
        .imem_addr(addr4), .imem_data(data4),
        .instruc_reg(ins4), .PC_plus_1(pcp4), .instr_valid(v4)
    );

    always @(posedge clk) begin
        data10 <= 32'h100 + 32'(addr10);
        data4  <= 32'h100 + 32'(addr4);
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        exp_t e, g;
        if (q10.size() > 0) begin
            e = q10.pop_front();
            g = '{v10, ins10, pcp10, addr10};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL fetch10 cyc %0d: got v=%b ins=%h pcp=%h addr=%h, want v=%b ins=%h pcp=%h addr=%h",
                         cyc_n, g.v, g.ins, g.pcp, g.addr, e.v, e.ins, e.pcp, e.addr);
            end
        end
        if (q4.size() > 0) begin
            e = q4.pop_front();
            g = '{v4, ins4, {6'd0, pcp4}, {6'd0, addr4}};
            n_chk++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL fetch4 cyc %0d: got v=%b ins=%h pcp=%h addr=%h, want v=%b ins=%h pcp=%h addr=%h",
                         cyc_n, g.v, g.ins, g.pcp, g.addr, e.v, e.ins, e.pcp, e.addr);
            end
        end
    end

    // Inputs for this cycle plus the output expected during this cycle.
    task automatic c10(input logic r, s, b, input logic [9:0] bt,
                       input logic j, input logic [9:0] jt,
                       input logic v, input logic [31:0] ins,
                       input logic [9:0] pcp, addr);
        rst = r; stl = s; br = b; ba = bt; jp = j; ja = jt;
        q10.push_back('{v, ins, pcp, addr});
        @(posedge clk); #1;
    endtask

    task automatic c4(input logic r, s, input logic v,
                      input logic [31:0] ins, input logic [3:0] pcp, addr);
        rst4 = r; stl4 = s;
        q4.push_back('{v, ins, {6'd0, pcp}, {6'd0, addr}});
        @(posedge clk); #1;
    endtask

    task automatic run10();
        c10(1,0,0,0,0,0,      0, 32'h0,   10'h0,   10'h0);
        c10(0,0,0,0,0,0,      0, 32'h0,   10'h0,   10'h0);
        c10(0,0,0,0,0,0,      1, 32'h100, 10'h1,   10'h1);
        c10(0,0,0,0,0,0,      1, 32'h101, 10'h2,   10'h2);
        c10(0,0,0,0,0,0,      1, 32'h102, 10'h3,   10'h3);
        c10(0,0,0,0,1,10'h200,1, 32'h103, 10'h4,   10'h4);
        c10(0,0,0,0,0,0,      0, 32'h0,   10'h0,   10'h200);
        c10(0,0,0,0,0,0,      1, 32'h300, 10'h201, 10'h201);
        c10(0,0,1,10'h40,1,10'h80, 1, 32'h301, 10'h202, 10'h202);
        c10(0,0,0,0,0,0,      0, 32'h0,   10'h0,   10'h40);
        c10(0,0,0,0,0,0,      1, 32'h140, 10'h41,  10'h41);
        c10(0,0,0,0,1,10'h5,  1, 32'h141, 10'h42,  10'h42);
        c10(0,0,0,0,0,0,      0, 32'h0,   10'h0,   10'h5);
        c10(0,0,0,0,0,0,      1, 32'h105, 10'h6,   10'h6);
        c10(0,0,0,0,0,0,      1, 32'h106, 10'h7,   10'h7);
        c10(0,1,0,0,0,0,      1, 32'h107, 10'h8,   10'h8);
        c10(0,1,0,0,0,0,      1, 32'h107, 10'h8,   10'h8);
        c10(0,1,0,0,0,0,      1, 32'h107, 10'h8,   10'h8);
        c10(0,0,0,0,0,0,      1, 32'h107, 10'h8,   10'h8);
        c10(0,0,0,0,0,0,      1, 32'h108, 10'h9,   10'h9);
        c10(0,1,0,0,0,0,      1, 32'h109, 10'hA,   10'hA);
        c10(0,1,0,0,1,10'h10, 1, 32'h109, 10'hA,   10'hA);
        c10(0,0,0,0,0,0,      0, 32'h0,   10'h0,   10'h10);
        c10(0,0,0,0,0,0,      1, 32'h110, 10'h11,  10'h11);
        c10(0,0,0,0,1,10'h3FE,1, 32'h111, 10'h12,  10'h12);
        c10(0,1,0,0,0,0,      0, 32'h0,   10'h0,   10'h3FE);
        c10(0,0,0,0,0,0,      0, 32'h0,   10'h0,   10'h3FE);
        c10(0,0,0,0,0,0,      1, 32'h4FE, 10'h3FF, 10'h3FF);
        c10(0,0,0,0,0,0,      1, 32'h4FF, 10'h0,   10'h0);
        c10(0,1,0,0,0,0,      1, 32'h100, 10'h1,   10'h1);
        c10(1,1,0,0,0,0,      1, 32'h100, 10'h1,   10'h1);
        c10(0,0,0,0,0,0,      0, 32'h0,   10'h0,   10'h0);
        c10(0,0,0,0,0,0,      1, 32'h100, 10'h1,   10'h1);
        c10(0,0,1,10'h20,0,0, 1, 32'h101, 10'h2,   10'h2);
        c10(1,0,0,0,0,0,      0, 32'h0,   10'h0,   10'h20);
        c10(0,0,0,0,0,0,      0, 32'h0,   10'h0,   10'h0);
        c10(0,0,0,0,0,0,      1, 32'h100, 10'h1,   10'h1);
    endtask

    task automatic run4();
        c4(1,0, 0, 32'h0,   4'd0,  4'd13);
        c4(0,0, 0, 32'h0,   4'd0,  4'd13);
        c4(0,0, 1, 32'h10D, 4'd14, 4'd14);
        c4(0,0, 1, 32'h10E, 4'd15, 4'd15);
        c4(0,0, 1, 32'h10F, 4'd0,  4'd0);
        c4(0,0, 1, 32'h100, 4'd1,  4'd1);
        c4(0,1, 1, 32'h101, 4'd2,  4'd2);
        c4(1,1, 1, 32'h101, 4'd2,  4'd2);
        c4(0,0, 0, 32'h0,   4'd0,  4'd13);
        c4(0,0, 1, 32'h10D, 4'd14, 4'd14);
    endtask

    initial begin
        int guard;
        rst = 1'b1; stl = 1'b0; br = 1'b0; jp = 1'b0; ba = '0; ja = '0;
        rst4 = 1'b1; stl4 = 1'b0;
        @(posedge clk); #1;
        fork
            run10();
            run4();
        join
        guard = 0;
        while ((q10.size() > 0 || q4.size() > 0) && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        if (q10.size() > 0 || q4.size() > 0) begin
            $display("FAIL drain: got %0d entries left, want 0",
                     q10.size() + q4.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
